// File: rtl/pkt_stat_pkg.sv
// Shared types and constants for the pkt_stat_d merged-stream monitor.
package pkt_stat_pkg;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_IN_PKT = 1'b1
  } state_e;

  localparam logic [2:0] ERR_NONE     = 3'd0;
  localparam logic [2:0] ERR_NO_SOP   = 3'd1;
  localparam logic [2:0] ERR_DUP_SOP  = 3'd2;
  localparam logic [2:0] ERR_CHAN_SW  = 3'd3;
  localparam logic [2:0] ERR_BAD_CHAN = 3'd4;
  localparam logic [2:0] ERR_BAD_MTY  = 3'd5;
  localparam logic [2:0] ERR_TOO_LONG = 3'd6;

  localparam int BYTES_PER_BEAT = 2;

endpackage

// File: rtl/pkt_stat_d_cnt.sv
// One channel's saturating packet/byte/error counters with a zero-gated read port.
module pkt_stat_cnt
  import pkt_stat_pkg::*;
#(
  parameter int PKT_CNT_W  = 16,
  parameter int BYTE_CNT_W = 24,
  parameter int ERR_CNT_W  = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clr,
  input  logic                  inc_pkt,
  input  logic [BYTE_CNT_W-1:0] add_byte,
  input  logic                  inc_err,
  input  logic                  rd_sel,
  output logic [PKT_CNT_W-1:0]  rd_pkt,
  output logic [BYTE_CNT_W-1:0] rd_byte,
  output logic [ERR_CNT_W-1:0]  rd_err
);

  logic [PKT_CNT_W-1:0]  pkt_q, pkt_d;
  logic [BYTE_CNT_W-1:0] byte_q, byte_d;
  logic [ERR_CNT_W-1:0]  err_q, err_d;
  logic [BYTE_CNT_W:0]   byte_sum;

  always_comb begin
    pkt_d    = pkt_q;
    byte_d   = byte_q;
    err_d    = err_q;
    byte_sum = {1'b0, byte_q} + {1'b0, add_byte};
    if (clr) begin
      pkt_d  = '0;
      byte_d = '0;
      err_d  = '0;
    end else begin
      if (inc_pkt && (pkt_q != '1)) pkt_d = pkt_q + 1'b1;
      if (inc_pkt) byte_d = byte_sum[BYTE_CNT_W] ? '1 : byte_sum[BYTE_CNT_W-1:0];
      if (inc_err && (err_q != '1)) err_d = err_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pkt_q  <= '0;
      byte_q <= '0;
      err_q  <= '0;
    end else begin
      pkt_q  <= pkt_d;
      byte_q <= byte_d;
      err_q  <= err_d;
    end
  end

  // Unselected channels drive zero so the top can OR all channels together.
  assign rd_pkt  = rd_sel ? pkt_q  : '0;
  assign rd_byte = rd_sel ? byte_q : '0;
  assign rd_err  = rd_sel ? err_q  : '0;

endmodule

// File: rtl/pkt_stat_d.sv
// Framing checker and per-channel statistics for the merged fifo_p stream.
// Optional packet length limit enabled by defining PKT_STAT_LEN_CHK_EN.
module pkt_stat_d
  import pkt_stat_pkg::*;
#(
  parameter int DATA_W     = 16,
  parameter int CHAN_NUM   = 3,
  parameter int PKT_CNT_W  = 16,
  parameter int BYTE_CNT_W = 24,
  parameter int ERR_CNT_W  = 8,
  parameter int MAX_BEATS  = 64
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_W-1:0]     din,
  input  logic                  din_vld,
  input  logic                  din_sop,
  input  logic                  din_eop,
  input  logic                  din_mty,
  input  logic [1:0]            din_chan,
  input  logic                  clr,
  input  logic                  rd_req,
  input  logic [1:0]            rd_chan,
  output logic                  stat_vld,
  output logic [PKT_CNT_W-1:0]  stat_pkt,
  output logic [BYTE_CNT_W-1:0] stat_byte,
  output logic [ERR_CNT_W-1:0]  stat_err,
  output logic                  err_pulse,
  output logic [2:0]            err_code
);

`ifdef PKT_STAT_LEN_CHK_EN
  localparam int BEAT_W = $clog2(MAX_BEATS + 1);
`else
  localparam int BEAT_W = BYTE_CNT_W;
  localparam int len_limit_unused = MAX_BEATS;
`endif

  logic din_unused;
  assign din_unused = ^din;

  state_e                state_q, state_d;
  logic                  drop_q, drop_d;
  logic [1:0]            chan_q, chan_d;
  logic [BEAT_W-1:0]     beats_q, beats_d, beats_inc;
  logic [BYTE_CNT_W-1:0] bytes_q, bytes_d, bytes_inc, pkt_total;
  logic [BYTE_CNT_W:0]   bytes_sum, tail_bytes, pkt_sum;
  logic                  err_pulse_q, err_pulse_d;
  logic [2:0]            err_code_q, err_code_d, err_now_code;
  logic                  err_now, err_charge, commit, start;
  logic [1:0]            err_ch, commit_ch;
  logic [BYTE_CNT_W-1:0] commit_bytes;

  // Per-beat framing decision; a sop seen mid-packet reports DUP_SOP and then
  // restarts exactly as from IDLE, but without reporting a second error.
  always_comb begin
    state_d      = state_q;
    drop_d       = drop_q;
    chan_d       = chan_q;
    beats_d      = beats_q;
    bytes_d      = bytes_q;
    err_now      = 1'b0;
    err_now_code = ERR_NONE;
    err_charge   = 1'b0;
    err_ch       = chan_q;
    commit       = 1'b0;
    commit_ch    = chan_q;
    commit_bytes = '0;
    start        = 1'b0;
    beats_inc    = (beats_q == '1) ? beats_q : beats_q + 1'b1;
    bytes_sum    = {1'b0, bytes_q} + (BYTE_CNT_W+1)'(BYTES_PER_BEAT);
    bytes_inc    = bytes_sum[BYTE_CNT_W] ? '1 : bytes_sum[BYTE_CNT_W-1:0];
    tail_bytes   = din_mty ? (BYTE_CNT_W+1)'(BYTES_PER_BEAT - 1) : (BYTE_CNT_W+1)'(BYTES_PER_BEAT);
    pkt_sum      = {1'b0, bytes_q} + tail_bytes;
    pkt_total    = pkt_sum[BYTE_CNT_W] ? '1 : pkt_sum[BYTE_CNT_W-1:0];

    if (clr) begin
      state_d = ST_IDLE;
      drop_d  = 1'b0;
      chan_d  = '0;
      beats_d = '0;
      bytes_d = '0;
    end else if (din_vld) begin
      case (state_q)
        ST_IDLE: begin
          if (!din_sop) begin
            err_now      = 1'b1;
            err_now_code = ERR_NO_SOP;
          end else begin
            start = 1'b1;
          end
        end
        default: begin
          if (drop_q) begin
            if (din_eop) state_d = ST_IDLE;
          end else if (din_sop) begin
            err_now      = 1'b1;
            err_now_code = ERR_DUP_SOP;
            err_charge   = 1'b1;
            start        = 1'b1;
          end else if (din_chan != chan_q) begin
            err_now      = 1'b1;
            err_now_code = ERR_CHAN_SW;
            err_charge   = 1'b1;
            state_d      = ST_IDLE;
          end else if (din_mty && !din_eop) begin
            err_now      = 1'b1;
            err_now_code = ERR_BAD_MTY;
            err_charge   = 1'b1;
            state_d      = ST_IDLE;
          end else begin
            beats_d = beats_inc;
            bytes_d = bytes_inc;
`ifdef PKT_STAT_LEN_CHK_EN
            if (int'(beats_q) >= MAX_BEATS) begin
              err_now      = 1'b1;
              err_now_code = ERR_TOO_LONG;
              err_charge   = 1'b1;
              state_d      = ST_IDLE;
            end else
`endif
            if (din_eop) begin
              commit       = 1'b1;
              commit_bytes = pkt_total;
              state_d      = ST_IDLE;
            end
          end
        end
      endcase

      if (start) begin
        if (int'(din_chan) >= CHAN_NUM) begin
          if (!err_now) begin
            err_now      = 1'b1;
            err_now_code = ERR_BAD_CHAN;
          end
          drop_d  = 1'b1;
          state_d = din_eop ? ST_IDLE : ST_IN_PKT;
        end else if (din_mty && !din_eop) begin
          if (!err_now) begin
            err_now      = 1'b1;
            err_now_code = ERR_BAD_MTY;
            err_charge   = 1'b1;
            err_ch       = din_chan;
          end
          state_d = ST_IDLE;
        end else if (din_eop) begin
          commit       = 1'b1;
          commit_ch    = din_chan;
          commit_bytes = tail_bytes[BYTE_CNT_W-1:0];
          state_d      = ST_IDLE;
        end else begin
          drop_d  = 1'b0;
          chan_d  = din_chan;
          beats_d = BEAT_W'(1);
          bytes_d = BYTE_CNT_W'(BYTES_PER_BEAT);
          state_d = ST_IN_PKT;
        end
      end
    end

    if (state_d == ST_IDLE) drop_d = 1'b0;
    err_pulse_d = err_now;
    err_code_d  = err_now ? err_now_code : err_code_q;
  end

  logic [PKT_CNT_W-1:0]  rd_pkt  [CHAN_NUM];
  logic [BYTE_CNT_W-1:0] rd_byte [CHAN_NUM];
  logic [ERR_CNT_W-1:0]  rd_err  [CHAN_NUM];

  for (genvar g = 0; g < CHAN_NUM; g++) begin : gen_chan
    pkt_stat_cnt #(
      .PKT_CNT_W  (PKT_CNT_W),
      .BYTE_CNT_W (BYTE_CNT_W),
      .ERR_CNT_W  (ERR_CNT_W)
    ) u_cnt (
      .clk      (clk),
      .rst_n    (rst_n),
      .clr      (clr),
      .inc_pkt  (commit && (commit_ch == 2'(g))),
      .add_byte (commit_bytes),
      .inc_err  (err_charge && (err_ch == 2'(g))),
      .rd_sel   (rd_chan == 2'(g)),
      .rd_pkt   (rd_pkt[g]),
      .rd_byte  (rd_byte[g]),
      .rd_err   (rd_err[g])
    );
  end

  logic                  stat_vld_q, stat_vld_d;
  logic [PKT_CNT_W-1:0]  stat_pkt_q, stat_pkt_d, pkt_any;
  logic [BYTE_CNT_W-1:0] stat_byte_q, stat_byte_d, byte_any;
  logic [ERR_CNT_W-1:0]  stat_err_q, stat_err_d, err_any;

  // Out-of-range rd_chan selects no channel, so the OR naturally returns zero.
  always_comb begin
    pkt_any  = '0;
    byte_any = '0;
    err_any  = '0;
    for (int i = 0; i < CHAN_NUM; i++) begin
      pkt_any  = pkt_any  | rd_pkt[i];
      byte_any = byte_any | rd_byte[i];
      err_any  = err_any  | rd_err[i];
    end
    stat_vld_d  = rd_req;
    stat_pkt_d  = rd_req ? pkt_any  : '0;
    stat_byte_d = rd_req ? byte_any : '0;
    stat_err_d  = rd_req ? err_any  : '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      drop_q      <= 1'b0;
      chan_q      <= '0;
      beats_q     <= '0;
      bytes_q     <= '0;
      err_pulse_q <= 1'b0;
      err_code_q  <= ERR_NONE;
      stat_vld_q  <= 1'b0;
      stat_pkt_q  <= '0;
      stat_byte_q <= '0;
      stat_err_q  <= '0;
    end else begin
      state_q     <= state_d;
      drop_q      <= drop_d;
      chan_q      <= chan_d;
      beats_q     <= beats_d;
      bytes_q     <= bytes_d;
      err_pulse_q <= err_pulse_d;
      err_code_q  <= err_code_d;
      stat_vld_q  <= stat_vld_d;
      stat_pkt_q  <= stat_pkt_d;
      stat_byte_q <= stat_byte_d;
      stat_err_q  <= stat_err_d;
    end
  end

  assign stat_vld  = stat_vld_q;
  assign stat_pkt  = stat_pkt_q;
  assign stat_byte = stat_byte_q;
  assign stat_err  = stat_err_q;
  assign err_pulse = err_pulse_q;
  assign err_code  = err_code_q;

endmodule
